// File: rtl/vid_pkg.sv
// Shared video definitions: position type, standard timing sets and a
// legality check for timing parameters.
package vid_pkg;

  localparam int POS_W = 12;

  typedef struct packed {
    logic [POS_W-1:0] hctr;
    logic [POS_W-1:0] vctr;
  } vid_pos_t;

  typedef struct packed {
    int htotal;
    int hdisp;
    int hsync_on;
    int hsync_off;
    int vtotal;
    int vdisp;
    int vsync_on;
    int vsync_off;
    bit hsync_pol;
    bit vsync_pol;
  } vid_timing_t;

  localparam vid_timing_t VID_1024X768 = '{1344, 1024, 1048, 1184, 806, 768, 771, 777, 1'b0, 1'b0};
  localparam vid_timing_t VID_800X600  = '{1056, 800, 840, 968, 628, 600, 601, 605, 1'b1, 1'b1};
  localparam vid_timing_t VID_640X480  = '{800, 640, 656, 752, 525, 480, 490, 492, 1'b0, 1'b0};

  // True when both axes are ordered display <= sync_on < sync_off <= total
  // and the last counter value fits in wid bits.
  function automatic bit vid_timing_ok(input int wid,
                                       input int htotal, input int hdisp,
                                       input int hs_on, input int hs_off,
                                       input int vtotal, input int vdisp,
                                       input int vs_on, input int vs_off);
    bit ok;
    ok = (wid > 0) && (wid < 31);
    ok = ok && (hdisp > 0) && (hdisp <= hs_on) && (hs_on < hs_off) && (hs_off <= htotal);
    ok = ok && (vdisp > 0) && (vdisp <= vs_on) && (vs_on < vs_off) && (vs_off <= vtotal);
    ok = ok && ((htotal - 1) < (1 << wid)) && ((vtotal - 1) < (1 << wid));
    return ok;
  endfunction

endpackage

// File: rtl/vid_sync_gen_if.sv
// Timing generator control/status bundle: pixel enable and genlock in,
// position, syncs, blank and frame strobes out.
interface vid_sync_gen_if #(parameter int WID = 12);
  logic           ce;
  logic           resync;
  logic [WID-1:0] hctr;
  logic [WID-1:0] vctr;
  logic           hsync;
  logic           vsync;
  logic           blank;
  logic           eol;
  logic           vbl;
  logic           sof;

  modport master (input ce, resync,
                  output hctr, vctr, hsync, vsync, blank, eol, vbl, sof);
  modport slave  (output ce, resync,
                  input hctr, vctr, hsync, vsync, blank, eol, vbl, sof);
endinterface

// File: rtl/vid_timing_axis.sv
// One timing axis: wrapping position counter with registered sync decode
// and next-state decode of the out-of-display region.
module vid_timing_axis #(
  parameter int WID      = 12,
  parameter int TOTAL    = 1344,
  parameter int DISP     = 1024,
  parameter int SYNC_ON  = 1048,
  parameter int SYNC_OFF = 1184,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  input  logic           load,
  output logic [WID-1:0] ctr,
  output logic           sync,
  output logic           outside_nxt,
  output logic           wrap
);

  localparam logic [WID-1:0] LAST = WID'(TOTAL - 1);
  localparam logic [WID-1:0] DISP_W = WID'(DISP);
  localparam logic [WID-1:0] ON_W = WID'(SYNC_ON);
  localparam logic [WID-1:0] OFF_W = WID'(SYNC_OFF);

  logic [WID-1:0] ctr_nxt;
  logic           sync_nxt;

  // load (genlock) overrides counting; wrap only reports a counted wrap.
  always_comb begin
    wrap    = inc && !load && (ctr == LAST);
    ctr_nxt = ctr;
    if (load)
      ctr_nxt = '0;
    else if (inc)
      ctr_nxt = wrap ? '0 : ctr + 1'b1;
    sync_nxt    = (ctr_nxt >= ON_W) && (ctr_nxt < OFF_W);
    outside_nxt = (ctr_nxt >= DISP_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr  <= '0;
      sync <= ~SYNC_POL;
    end else if (inc || load) begin
      ctr  <= ctr_nxt;
      sync <= sync_nxt ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vid_sync_gen.sv
// Video timing generator: horizontal/vertical counters advanced on the pixel
// enable, decoded into registered syncs, blank and frame strobes.
module vid_sync_gen
  import vid_pkg::*;
#(
  parameter int WID       = 12,
  parameter int HTOTAL    = 1344,
  parameter int HDISP     = 1024,
  parameter int HSYNC_ON  = 1048,
  parameter int HSYNC_OFF = 1184,
  parameter int VTOTAL    = 806,
  parameter int VDISP     = 768,
  parameter int VSYNC_ON  = 771,
  parameter int VSYNC_OFF = 777,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  vid_sync_gen_if.master   vif
);

  if (!vid_timing_ok(WID, HTOTAL, HDISP, HSYNC_ON, HSYNC_OFF,
                     VTOTAL, VDISP, VSYNC_ON, VSYNC_OFF)) begin : g_bad_cfg
    $error("vid_sync_gen: illegal timing parameters");
  end

  localparam logic [WID-1:0] VBL_PREV = WID'(VDISP - 1);

  logic h_wrap;
  logic v_wrap;
  logic h_out;
  logic v_out;
  logic v_inc;

  assign v_inc = vif.ce && h_wrap;

  vid_timing_axis #(
    .WID(WID), .TOTAL(HTOTAL), .DISP(HDISP),
    .SYNC_ON(HSYNC_ON), .SYNC_OFF(HSYNC_OFF), .SYNC_POL(HSYNC_POL)
  ) u_haxis (
    .clk(clk), .rst(rst), .inc(vif.ce), .load(vif.resync),
    .ctr(vif.hctr), .sync(vif.hsync), .outside_nxt(h_out), .wrap(h_wrap)
  );

  vid_timing_axis #(
    .WID(WID), .TOTAL(VTOTAL), .DISP(VDISP),
    .SYNC_ON(VSYNC_ON), .SYNC_OFF(VSYNC_OFF), .SYNC_POL(VSYNC_POL)
  ) u_vaxis (
    .clk(clk), .rst(rst), .inc(v_inc), .load(vif.resync),
    .ctr(vif.vctr), .sync(vif.vsync), .outside_nxt(v_out), .wrap(v_wrap)
  );

  // h_wrap already excludes resync, so only sof can fire on a genlock clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      vif.blank <= 1'b1;
      vif.eol   <= 1'b0;
      vif.vbl   <= 1'b0;
      vif.sof   <= 1'b0;
    end else begin
      if (vif.ce || vif.resync)
        vif.blank <= h_out || v_out;
      vif.eol <= h_wrap;
      vif.vbl <= h_wrap && (vif.vctr == VBL_PREV);
      vif.sof <= vif.resync || (h_wrap && v_wrap);
    end
  end

endmodule

// File: tb/tb_vid_sync_gen.sv
// Directed plus randomized bench for vid_sync_gen on a small 10x5 raster,
// checked against a raster-position reference model.
module tb_vid_sync_gen;
  import vid_pkg::*;

  localparam int WID = 4;
  localparam int HT = 10, HD = 6, HS_ON = 7, HS_OFF = 9;
  localparam int VT = 5, VD = 3, VS_ON = 3, VS_OFF = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // reference model state
  vid_pos_t mpos;
  logic     m_blank, m_hs, m_vs, m_eol, m_vbl, m_sof;

  vid_sync_gen_if #(.WID(WID)) vif ();

  vid_sync_gen #(
    .WID(WID), .HTOTAL(HT), .HDISP(HD), .HSYNC_ON(HS_ON), .HSYNC_OFF(HS_OFF),
    .VTOTAL(VT), .VDISP(VD), .VSYNC_ON(VS_ON), .VSYNC_OFF(VS_OFF),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .vif(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: position as a linear pixel index in the frame; outputs derive
  // from where that pixel lies on the raster (active-low syncs).
  task automatic model_apply(input logic r, input logic rs, input logic c);
    int n;
    m_eol = 1'b0; m_vbl = 1'b0; m_sof = 1'b0;
    if (r) begin
      mpos = '0;
      m_blank = 1'b1; m_hs = 1'b1; m_vs = 1'b1;
    end else if (rs || c) begin
      if (rs) begin
        n = 0;
        m_sof = 1'b1;
      end else begin
        n = (int'(mpos.vctr) * HT + int'(mpos.hctr) + 1) % (HT * VT);
        m_eol = (n % HT == 0);
        m_vbl = (n == VD * HT);
        m_sof = (n == 0);
      end
      mpos.hctr = POS_W'(n % HT);
      mpos.vctr = POS_W'(n / HT);
      m_blank = (n % HT >= HD) || (n / HT >= VD);
      m_hs = !((n % HT >= HS_ON) && (n % HT < HS_OFF));
      m_vs = !((n / HT >= VS_ON) && (n / HT < VS_OFF));
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hctr"}, 32'(vif.hctr), 32'(mpos.hctr[WID-1:0]));
    check({tag, ".vctr"}, 32'(vif.vctr), 32'(mpos.vctr[WID-1:0]));
    check({tag, ".hsync"}, 32'(vif.hsync), 32'(m_hs));
    check({tag, ".vsync"}, 32'(vif.vsync), 32'(m_vs));
    check({tag, ".blank"}, 32'(vif.blank), 32'(m_blank));
    check({tag, ".eol"}, 32'(vif.eol), 32'(m_eol));
    check({tag, ".vbl"}, 32'(vif.vbl), 32'(m_vbl));
    check({tag, ".sof"}, 32'(vif.sof), 32'(m_sof));
  endtask

  task automatic step(input string tag, input logic r, input logic rs, input logic c);
    rst = r; vif.resync = rs; vif.ce = c;
    @(posedge clk);
    #1;
    model_apply(r, rs, c);
    check_all(tag);
  endtask

  task automatic goto_pos(input string tag, input int h, input int v);
    bit reached;
    reached = (int'(mpos.hctr) == h) && (int'(mpos.vctr) == v);
    for (int i = 0; i < 2 * HT * VT && !reached; i++) begin
      step(tag, 1'b0, 1'b0, 1'b1);
      reached = (int'(mpos.hctr) == h) && (int'(mpos.vctr) == v);
    end
    check({tag, ".reached"}, 32'(reached), 32'd1);
  endtask

  initial begin
    int vbl_cnt, eolsof_cnt, ce0_strobes, frame_clks;
    bit got_sof;
    checks = 0; errors = 0;
    mpos = '0; m_blank = 1'b1; m_hs = 1'b1; m_vs = 1'b1;
    m_eol = 1'b0; m_vbl = 1'b0; m_sof = 1'b0;
    rst = 1'b1; vif.ce = 1'b0; vif.resync = 1'b0;

    // reset state
    step("rst0", 1'b1, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b0, 1'b1);
    check("rst.blank_lit", 32'(vif.blank), 32'd1);

    // first line, then remainder of the frame
    vbl_cnt = 0; eolsof_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step("run", 1'b0, 1'b0, 1'b1);
      if (vif.vbl) vbl_cnt++;
      if (vif.eol && vif.sof) eolsof_cnt++;
      if (i == HS_ON - 1) check("run.hsync_at7", 32'(vif.hsync), 32'd0);
      if (i == HT - 1) check("run.eol_at_0_1", 32'({vif.eol, vif.hctr, vif.vctr}), 32'({1'b1, 4'd0, 4'd1}));
    end
    check("frame.vbl_once", 32'(vbl_cnt), 32'd1);
    check("frame.eol_sof_once", 32'(eolsof_cnt), 32'd1);

    // ce toggling: frame takes twice as long, no strobes on idle clks
    ce0_strobes = 0; frame_clks = 0; got_sof = 1'b0;
    for (int i = 0; i < 4 * HT * VT && !got_sof; i++) begin
      step("tog", 1'b0, 1'b0, (i % 2) == 1);
      frame_clks++;
      if ((i % 2) == 0 && (vif.eol || vif.vbl || vif.sof)) ce0_strobes++;
      if (vif.sof) got_sof = 1'b1;
    end
    check("tog.frame_clks", 32'(frame_clks), 32'(2 * HT * VT));
    check("tog.ce0_strobes", 32'(ce0_strobes), 32'd0);

    // genlock at (5,2) with ce low
    goto_pos("to52", 5, 2);
    step("resync", 1'b0, 1'b1, 1'b0);
    check("resync.lit", 32'({vif.hctr, vif.vctr, vif.blank, vif.sof, vif.hsync, vif.vsync}),
          32'({4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1}));

    // reset mid-frame at (8,3), then counting resumes
    goto_pos("to83", 8, 3);
    step("midrst", 1'b1, 1'b0, 1'b1);
    check("midrst.lit", 32'({vif.hctr, vif.vctr, vif.blank, vif.hsync, vif.vsync, vif.eol, vif.vbl, vif.sof}),
          32'({4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 3'b000}));
    step("resume", 1'b0, 1'b0, 1'b1);
    check("resume.hctr", 32'(vif.hctr), 32'd1);

    // rst and resync together at (4,4): rst wins
    goto_pos("to44", 4, 4);
    step("rst_resync", 1'b1, 1'b1, 1'b1);
    check("rst_resync.sof", 32'(vif.sof), 32'd0);

    // randomized enable / genlock / reset traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
